bw_seq_mult: RTL

Sequential, parametrised signed Baugh-Wooley multiplier for the signed ALU datapath. It takes two WIDTH-bit two's-complement operands through a valid/ready handshake and accumulates one partial-product row per cycle in a registered carry-save pair. It then resolves the product with one carry-propagate add and returns the full 2·WIDTH-bit signed product through a second valid/ready handshake. It is the iterative, width-generic successor to the combinational carry-save array cell, trading area for latency.

---
 rtl/bw_seq_mult.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bw_seq_mult.sv
// Sequential signed Baugh-Wooley multiplier: one partial-product row per cycle into a carry-save pair.
// Optional saturated output enabled by defining BW_SEQ_MULT_SAT_EN.
module bw_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
`ifdef BW_SEQ_MULT_SAT_EN
  ,
  output logic [WIDTH-1:0]   sat_product,
  output logic               sat_flag
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);
  // Baugh-Wooley correction constant, folded into the sum register at accept time
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    row_idx;
  logic [PW-1:0]    s_q;
  logic [PW-1:0]    c_q;
  logic [WIDTH-1:0] row_bits;
  logic [PW-1:0]    row_vec;
  logic [PW-1:0]    s_next;
  logic [PW-1:0]    c_next;
  logic [PW-1:0]    sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ACC;
      ACC:     if (row_idx == LAST_ROW) state_next = RESOLVE;
      RESOLVE: state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Row terms that mix exactly one sign bit are inverted; the constant preload absorbs the correction
  always_comb begin
    row_bits = '0;
    for (int j = 0; j < WIDTH; j++) begin
      row_bits[j] = a_q[j] & b_q[row_idx];
      if ((row_idx == LAST_ROW) != (j == WIDTH - 1))
        row_bits[j] = ~row_bits[j];
    end
    row_vec = {{WIDTH{1'b0}}, row_bits} << row_idx;
    s_next  = s_q ^ c_q ^ row_vec;
    c_next  = ((s_q & c_q) | (s_q & row_vec) | (c_q & row_vec)) << 1;
  end

  assign sum = s_q + c_q;

`ifdef BW_SEQ_MULT_SAT_EN
  logic             sum_fits;
  logic [WIDTH-1:0] sat_value;

  // The product fits in WIDTH bits when its top WIDTH+1 bits are all copies of the sign
  always_comb begin
    sum_fits  = (&sum[PW-1:WIDTH-1]) | ~(|sum[PW-1:WIDTH-1]);
    sat_value = sum[WIDTH-1:0];
    if (!sum_fits)
      sat_value = sum[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      row_idx     <= '0;
      s_q         <= '0;
      c_q         <= '0;
      product     <= '0;
`ifdef BW_SEQ_MULT_SAT_EN
      sat_product <= '0;
      sat_flag    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q     <= a;
            b_q     <= b;
            row_idx <= '0;
            s_q     <= BW_CORR;
            c_q     <= '0;
          end
        end
        ACC: begin
          s_q     <= s_next;
          c_q     <= c_next;
          row_idx <= row_idx + CW'(1);
        end
        RESOLVE: begin
          product     <= sum;
`ifdef BW_SEQ_MULT_SAT_EN
          sat_product <= sat_value;
          sat_flag    <= ~sum_fits;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
